svk_apb_slv_regbank: RTL and testbench



---
 rtl/svk_apb_slv_pkg.sv | 16 +
 rtl/svk_apb_slv_wait_ctr.sv | 21 ++
 rtl/svk_apb_slv_regbank.sv | 79 +++++++
 tb/tb_svk_apb_slv_regbank.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/svk_apb_slv_pkg.sv
// svk_apb_slv_pkg: shared FSM state type and decode-width helpers for the APB register bank
package svk_apb_slv_pkg;
    typedef enum logic [0:0] {IDLE = 1'b0, ACCESS = 1'b1} state_t;
    localparam int DEF_DATA_WIDTH = 32;
    localparam int STRB_W = DEF_DATA_WIDTH / 8;
    localparam int OFF_BITS = $clog2(STRB_W);
    function automatic int idx_bits(input int num_regs);
        return (num_regs < 2) ? 1 : $clog2(num_regs);
    endfunction
    function automatic int strb_bits(input int data_width);
        return data_width / 8;
    endfunction
    function automatic int off_bits(input int data_width);
        return $clog2(data_width / 8);
    endfunction
endpackage

// File: rtl/svk_apb_slv_wait_ctr.sv
// svk_apb_slv_wait_ctr: wait-state counter and pready generation for the APB completer
module svk_apb_slv_wait_ctr #(
    parameter int WAIT_CYCLES = 0
) (
    input  logic pclk,
    input  logic presetn,
    input  logic clr,
    input  logic active,
    input  logic psel,
    input  logic penable,
    output logic pready
);
    localparam logic [3:0] WC = 4'(WAIT_CYCLES);
    logic [3:0] cnt;
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) cnt <= '0;
        else if (clr) cnt <= '0;
        else if (active && cnt < WC) cnt <= cnt + 4'd1;
    end
    assign pready = active && (cnt == WC) && psel && penable;
endmodule

// File: rtl/svk_apb_slv_regbank.sv
// svk_apb_slv_regbank: APB completer register bank with fixed wait states and a write-notify port
// Define SVK_APB_SLV_PROT_CHECK_EN to make the upper register half require pprot[0]=1.
import svk_apb_slv_pkg::*;
module svk_apb_slv_regbank #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int NUM_REGS    = 16,
    parameter int WAIT_CYCLES = 0
) (
    input  logic                        pclk,
    input  logic                        presetn,
    input  logic [ADDR_WIDTH-1:0]       paddr,
    input  logic                        psel,
    input  logic                        penable,
    input  logic                        pwrite,
    input  logic [DATA_WIDTH-1:0]       pwdata,
    input  logic [DATA_WIDTH/8-1:0]     pstrb,
    input  logic [2:0]                  pprot,
    output logic [DATA_WIDTH-1:0]       prdata,
    output logic                        pready,
    output logic                        pslverr,
    output logic                        wr_pulse,
    output logic [$clog2(NUM_REGS)-1:0] wr_idx
);
    localparam int SW = strb_bits(DATA_WIDTH);
    localparam int OB = off_bits(DATA_WIDTH);
    localparam int IW = idx_bits(NUM_REGS);
    state_t state, next_state;
    logic [IW-1:0] idx;
    logic err, prot_err, commit;
    logic [DATA_WIDTH-1:0] regs [NUM_REGS];
    svk_apb_slv_wait_ctr #(.WAIT_CYCLES(WAIT_CYCLES)) u_wait (
        .pclk(pclk),
        .presetn(presetn),
        .clr(state == IDLE),
        .active(state == ACCESS),
        .psel(psel),
        .penable(penable),
        .pready(pready)
    );
`ifdef SVK_APB_SLV_PROT_CHECK_EN
    assign prot_err = idx[IW-1] && !pprot[0];
`else
    logic unused_pprot;
    assign unused_pprot = ^pprot;
    assign prot_err = 1'b0;
`endif
    // Masking/shifting instead of slicing keeps the decode legal when DATA_WIDTH=8 (no offset bits).
    always_comb begin
        idx    = IW'(paddr >> OB);
        err    = |(paddr & ADDR_WIDTH'(SW - 1)) || |(paddr >> (OB + IW)) || prot_err;
        commit = pready && pwrite && !err;
        prdata = (pready && !pwrite && !err) ? regs[idx] : '0;
        pslverr = pready && err;
    end
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (psel && !penable) next_state = ACCESS;
            ACCESS:  if (pready || !psel) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state    <= IDLE;
            wr_pulse <= 1'b0;
            wr_idx   <= '0;
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else begin
            state    <= next_state;
            wr_pulse <= commit;
            if (commit) wr_idx <= idx;
            if (commit)
                for (int b = 0; b < SW; b++)
                    if (pstrb[b]) regs[idx][8*b +: 8] <= pwdata[8*b +: 8];
        end
    end
endmodule

// File: tb/tb_svk_apb_slv_regbank.sv
// tb_svk_apb_slv_regbank: scoreboard bench driving a zero-wait and a three-wait instance of the register bank
module tb_svk_apb_slv_regbank;
    typedef struct {
        int          d;
        logic        wr;
        logic [31:0] rdata;
        logic        err;
        logic [3:0]  idx;
        int          waits;
    } exp_t;
    exp_t q[$];
    logic pclk = 1'b0;
    logic presetn = 1'b0;
    logic [31:0] paddr = '0;
    logic [31:0] pwdata = '0;
    logic [1:0] psel = '0;
    logic penable = 1'b0;
    logic pwrite = 1'b0;
    logic [3:0] pstrb = '0;
    logic [2:0] pprot = '0;
    logic [1:0] pready_w, pslverr_w, wr_pulse_w;
    logic [31:0] prdata_w [2];
    logic [3:0] wr_idx_w [2];
    int checks = 0;
    int fails = 0;
    int cyc = 0;
    int done_cyc = 0;
    int waits [2] = '{0, 0};
    logic exp_wp [2] = '{1'b0, 1'b0};
    logic [3:0] exp_wi [2] = '{4'd0, 4'd0};
    always #5 pclk = ~pclk;
    always @(posedge pclk) cyc++;
    svk_apb_slv_regbank #(.WAIT_CYCLES(0)) dut0 (
        .pclk(pclk), .presetn(presetn), .paddr(paddr), .psel(psel[0]), .penable(penable),
        .pwrite(pwrite), .pwdata(pwdata), .pstrb(pstrb), .pprot(pprot), .prdata(prdata_w[0]),
        .pready(pready_w[0]), .pslverr(pslverr_w[0]), .wr_pulse(wr_pulse_w[0]), .wr_idx(wr_idx_w[0])
    );
    svk_apb_slv_regbank #(.WAIT_CYCLES(3)) dut1 (
        .pclk(pclk), .presetn(presetn), .paddr(paddr), .psel(psel[1]), .penable(penable),
        .pwrite(pwrite), .pwdata(pwdata), .pstrb(pstrb), .pprot(pprot), .prdata(prdata_w[1]),
        .pready(pready_w[1]), .pslverr(pslverr_w[1]), .wr_pulse(wr_pulse_w[1]), .wr_idx(wr_idx_w[1])
    );
    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at cycle %0d", n, act, exp, cyc);
        end
    endtask
    // Monitor: pops the oldest expectation whenever a completer raises pready.
    always @(negedge pclk) begin
        exp_t e;
        logic nwp;
        logic [3:0] nwi;
        for (int d = 0; d < 2; d++) begin
            nwp = 1'b0;
            nwi = '0;
            if (!presetn || !psel[d]) waits[d] = 0;
            if (pready_w[d]) begin
                if (q.size() == 0 || q[0].d != d) begin
                    checks++;
                    fails++;
                    $display("FAIL unexpected_pready dut%0d at cycle %0d", d, cyc);
                end else begin
                    e = q.pop_front();
                    chk("pslverr", 32'(pslverr_w[d]), 32'(e.err));
                    chk("wait_cycles", waits[d], e.waits);
                    if (!e.wr) chk("prdata", prdata_w[d], e.rdata);
                    nwp = e.wr && !e.err;
                    nwi = e.idx;
                    done_cyc = cyc;
                end
                waits[d] = 0;
            end else begin
                if (presetn && psel[d] && penable) waits[d]++;
                chk("pslverr_not_ready", 32'(pslverr_w[d]), 32'd0);
                chk("prdata_not_ready", prdata_w[d], 32'd0);
            end
            chk("wr_pulse", 32'(wr_pulse_w[d]), 32'(exp_wp[d]));
            if (exp_wp[d]) chk("wr_idx", 32'(wr_idx_w[d]), 32'(exp_wi[d]));
            exp_wp[d] = nwp;
            exp_wi[d] = nwi;
        end
    end
    task automatic xfer(input int d, input logic [31:0] a, input logic w, input logic [31:0] wd,
                        input logic [3:0] st, input logic [2:0] pr, input logic [31:0] er,
                        input logic ee, input int wt);
        q.push_back('{d: d, wr: w, rdata: er, err: ee, idx: a[5:2], waits: wt});
        paddr = a;
        pwrite = w;
        pwdata = wd;
        pstrb = st;
        pprot = pr;
        psel[d] = 1'b1;
        penable = 1'b0;
        @(posedge pclk);
        #1 penable = 1'b1;
        for (int i = 0; ; i++) begin
            @(negedge pclk);
            if (pready_w[d]) break;
            if (i >= 40) begin
                checks++;
                fails++;
                $display("FAIL pready_timeout dut%0d addr %h", d, a);
                break;
            end
        end
        @(posedge pclk);
        #1 psel = '0;
        penable = 1'b0;
    endtask
    task automatic idle(input int n);
        repeat (n) @(posedge pclk);
        #1;
    endtask
    initial begin
        int t;
        repeat (2) @(posedge pclk);
        @(negedge pclk);
        for (int d = 0; d < 2; d++) begin
            chk("reset_pready", 32'(pready_w[d]), 32'd0);
            chk("reset_pslverr", 32'(pslverr_w[d]), 32'd0);
            chk("reset_prdata", prdata_w[d], 32'd0);
            chk("reset_wr_idx", 32'(wr_idx_w[d]), 32'd0);
        end
        @(posedge pclk);
        #1 presetn = 1'b1;
        idle(1);
        xfer(0, 32'h04, 1, 32'hDEADBEEF, 4'hF, 3'd0, 32'h0, 0, 0);
        xfer(0, 32'h04, 0, 32'h0, 4'hF, 3'd0, 32'hDEADBEEF, 0, 0);
        idle(1);
        xfer(0, 32'h00, 1, 32'h11223344, 4'hF, 3'd0, 32'h0, 0, 0);
        xfer(0, 32'h00, 1, 32'hAABBCCDD, 4'h5, 3'd0, 32'h0, 0, 0);
        xfer(0, 32'h00, 0, 32'h0, 4'h0, 3'd0, 32'h11BB33DD, 0, 0);
        xfer(0, 32'h0C, 1, 32'h99999999, 4'h0, 3'd0, 32'h0, 0, 0);
        xfer(0, 32'h0C, 0, 32'h0, 4'hF, 3'd0, 32'h0, 0, 0);
        xfer(0, 32'h02, 1, 32'hFFFFFFFF, 4'hF, 3'd0, 32'h0, 1, 0);
        xfer(0, 32'h40, 1, 32'hFFFFFFFF, 4'hF, 3'd0, 32'h0, 1, 0);
        xfer(0, 32'h40, 0, 32'h0, 4'hF, 3'd0, 32'h0, 1, 0);
        xfer(0, 32'h00, 0, 32'h0, 4'hF, 3'd0, 32'h11BB33DD, 0, 0);
        xfer(0, 32'h04, 0, 32'h0, 4'hF, 3'd0, 32'hDEADBEEF, 0, 0);
        idle(2);
        xfer(0, 32'h08, 1, 32'h12345678, 4'hF, 3'd0, 32'h0, 0, 0);
        t = done_cyc;
        xfer(0, 32'h0C, 1, 32'hCAFEF00D, 4'hF, 3'd0, 32'h0, 0, 0);
        chk("b2b_gap", done_cyc - t, 2);
        xfer(0, 32'h08, 0, 32'h0, 4'hF, 3'd0, 32'h12345678, 0, 0);
        xfer(0, 32'h0C, 0, 32'h0, 4'hF, 3'd0, 32'hCAFEF00D, 0, 0);
        idle(1);
        xfer(1, 32'h08, 1, 32'h55AA55AA, 4'hF, 3'd0, 32'h0, 0, 3);
        xfer(1, 32'h08, 0, 32'h0, 4'hF, 3'd0, 32'h55AA55AA, 0, 3);
        paddr = 32'h10;
        pwrite = 1'b1;
        pwdata = 32'hFFFFFFFF;
        pstrb = 4'hF;
        psel[1] = 1'b1;
        penable = 1'b0;
        @(posedge pclk);
        #1 penable = 1'b1;
        @(posedge pclk);
        #1 psel = '0;
        penable = 1'b0;
        idle(1);
        xfer(1, 32'h10, 0, 32'h0, 4'hF, 3'd0, 32'h0, 0, 3);
        xfer(1, 32'h40, 0, 32'h0, 4'hF, 3'd0, 32'h0, 1, 3);
`ifdef SVK_APB_SLV_PROT_CHECK_EN
        xfer(0, 32'h30, 1, 32'h0BADF00D, 4'hF, 3'd0, 32'h0, 1, 0);
        xfer(0, 32'h30, 0, 32'h0, 4'hF, 3'd1, 32'h0, 0, 0);
        xfer(0, 32'h30, 1, 32'h0BADF00D, 4'hF, 3'd1, 32'h0, 0, 0);
        xfer(0, 32'h30, 0, 32'h0, 4'hF, 3'd0, 32'h0, 1, 0);
        xfer(0, 32'h30, 0, 32'h0, 4'hF, 3'd1, 32'h0BADF00D, 0, 0);
        xfer(0, 32'h1C, 0, 32'h0, 4'hF, 3'd0, 32'h0, 0, 0);
`endif
        paddr = 32'h14;
        pwrite = 1'b1;
        pwdata = 32'h77777777;
        pstrb = 4'hF;
        psel[1] = 1'b1;
        penable = 1'b0;
        @(posedge pclk);
        #1 penable = 1'b1;
        @(negedge pclk);
        #2 presetn = 1'b0;
        #1;
        chk("rst_mid_pready", 32'(pready_w[1]), 32'd0);
        chk("rst_mid_pslverr", 32'(pslverr_w[1]), 32'd0);
        chk("rst_mid_prdata", prdata_w[1], 32'd0);
        psel = '0;
        penable = 1'b0;
        @(posedge pclk);
        #1 presetn = 1'b1;
        for (int i = 0; i < 16; i++) xfer(0, 32'(i * 4), 0, 32'h0, 4'hF, 3'd1, 32'h0, 0, 0);
        xfer(1, 32'h08, 0, 32'h0, 4'hF, 3'd0, 32'h0, 0, 3);
        xfer(1, 32'h14, 0, 32'h0, 4'hF, 3'd0, 32'h0, 0, 3);
        idle(3);
        chk("scoreboard_drained", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
